// File: rtl/lotr_pkg.sv
// Shared types and defaults for the host-side UART transmitter.
package lotr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } t_uart_tx_state;

    localparam int unsigned UART_HOST_DEFAULT_CLK_DIV    = 434;
    localparam int unsigned UART_HOST_DEFAULT_FIFO_DEPTH = 4;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with occupancy output; read data is the head entry, visible while non-empty.
module uart_tx_fifo #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/uart_host_tx.sv
// Host UART transmitter: FIFO-buffered 8N1 serializer, LSB first.
// Define UART_HOST_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_host_tx
    import lotr_pkg::*;
#(
    parameter  int unsigned CLK_DIV    = UART_HOST_DEFAULT_CLK_DIV,
    parameter  int unsigned FIFO_DEPTH = UART_HOST_DEFAULT_FIFO_DEPTH,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             uart_tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    t_uart_tx_state   state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             uart_tx_q;
`ifdef UART_HOST_TX_PARITY_EN
    logic             parity_q;
`endif

    logic [7:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;
    logic       baud_tc_c;
    logic       pop_c;
    logic       line_c;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign baud_tc_c = (baud_cnt_q == CNT_W'(CLK_DIV - 1));
    // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
    assign pop_c = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_tc_c));

    always_comb begin
        line_c = 1'b1;
        case (state_q)
            START:   line_c = 1'b0;
            DATA:    line_c = shift_q[0];
`ifdef UART_HOST_TX_PARITY_EN
            PARITY:  line_c = parity_q;
`endif
            default: line_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
`ifdef UART_HOST_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            uart_tx_q <= line_c;
            if ((state_q == IDLE) || baud_tc_c) baud_cnt_q <= '0;
            else                                baud_cnt_q <= baud_cnt_q + CNT_W'(1);

            if (pop_c) begin
                state_q   <= START;
                shift_q   <= fifo_rdata;
                bit_idx_q <= '0;
`ifdef UART_HOST_TX_PARITY_EN
                parity_q  <= even_parity(fifo_rdata);
`endif
            end else begin
                case (state_q)
                    IDLE:  state_q <= IDLE;
                    START: if (baud_tc_c) state_q <= DATA;
                    DATA: begin
                        if (baud_tc_c) begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_HOST_TX_PARITY_EN
                            if (bit_idx_q == 3'd7) state_q <= PARITY;
`else
                            if (bit_idx_q == 3'd7) state_q <= STOP;
`endif
                        end
                    end
`ifdef UART_HOST_TX_PARITY_EN
                    PARITY: if (baud_tc_c) state_q <= STOP;
`endif
                    STOP:    if (baud_tc_c) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign uart_tx  = uart_tx_q;
    assign tx_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule
